// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter: streaming 3x3 Sobel with two line buffers, 3-cycle latency, border masking.
// Define SOBEL_MAG_EN to build the |Gx|+|Gy| magnitude output; otherwise mag is tied to 0.
module sobel_stream_filter #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int COL_W  = 13,
    parameter int ROW_W  = 13,
    parameter int GRAD_W = 8,
    parameter int SHIFT  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] pix,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic              out_valid,
    output logic [GRAD_W-1:0] xgrad,
    output logic [GRAD_W-1:0] ygrad,
    output logic [GRAD_W-1:0] mag,
    output logic              border,
    output logic [ROW_W-1:0]  rowout,
    output logic [COL_W-1:0]  colout
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int SW = DATA_W + 3;
    localparam logic [COL_W-1:0] IMG_WC = COL_W'(IMG_W);
    localparam logic signed [SW-1:0] SMAX = SW'((2 ** (GRAD_W - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);

    function automatic logic signed [SW-1:0] ext(input logic [DATA_W-1:0] p);
        return signed'({3'b000, p});
    endfunction

    function automatic logic signed [SW-1:0] wsum(input logic [DATA_W-1:0] a, b, c);
        return ext(a) + (ext(b) <<< 1) + ext(c);
    endfunction

    function automatic logic [GRAD_W-1:0] sat_s(input logic signed [SW-1:0] v);
        return (v > SMAX) ? SMAX[GRAD_W-1:0] : (v < SMIN) ? SMIN[GRAD_W-1:0] : v[GRAD_W-1:0];
    endfunction

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] rd0, rd1;
    logic              in_range;
    logic [AW-1:0]     addr;

    assign in_range = col < IMG_WC;
    assign addr     = col[AW-1:0];

    // Registered read: a same-address write this cycle still returns the old rows.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            rd0 <= lb0[addr];
            rd1 <= lb1[addr];
        end
        if (in_valid && in_range) begin
            lb0[addr] <= pix;
            lb1[addr] <= lb0[addr];
        end
    end

    logic              v1, v2, v3;
    logic              b1, b2, b3;
    logic [DATA_W-1:0] p1;
    logic [ROW_W-1:0]  r1, r2, r3;
    logic [COL_W-1:0]  c1, c2, c3;
    logic [DATA_W-1:0] w [3][3];
    logic signed [SW-1:0] gx3, gy3, gx_c, gy_c, gx_s, gy_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            b1 <= 1'b0;
            p1 <= '0;
            r1 <= '0;
            c1 <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                p1 <= pix;
                r1 <= row - ROW_W'(1);
                c1 <= col - COL_W'(1);
                b1 <= (row < ROW_W'(2)) || (col < COL_W'(2)) || !in_range;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            b2 <= 1'b0;
            r2 <= '0;
            c2 <= '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[i][j] <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                b2 <= b1;
                r2 <= r1;
                c2 <= c1;
                for (int i = 0; i < 3; i++) begin
                    w[i][0] <= w[i][1];
                    w[i][1] <= w[i][2];
                end
                w[0][2] <= rd1;
                w[1][2] <= rd0;
                w[2][2] <= p1;
            end
        end
    end

    always_comb begin
        gx_c = wsum(w[0][2], w[1][2], w[2][2]) - wsum(w[0][0], w[1][0], w[2][0]);
        gy_c = wsum(w[2][0], w[2][1], w[2][2]) - wsum(w[0][0], w[0][1], w[0][2]);
        gx_s = gx3 >>> SHIFT;
        gy_s = gy3 >>> SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3  <= 1'b0;
            b3  <= 1'b0;
            r3  <= '0;
            c3  <= '0;
            gx3 <= '0;
            gy3 <= '0;
        end else begin
            v3 <= v2;
            if (v2) begin
                b3  <= b2;
                r3  <= r2;
                c3  <= c2;
                gx3 <= gx_c;
                gy3 <= gy_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            xgrad     <= '0;
            ygrad     <= '0;
            border    <= 1'b0;
            rowout    <= '0;
            colout    <= '0;
        end else begin
            out_valid <= v3;
            if (v3) begin
                xgrad  <= b3 ? '0 : sat_s(gx_s);
                ygrad  <= b3 ? '0 : sat_s(gy_s);
                border <= b3;
                rowout <= r3;
                colout <= c3;
            end
        end
    end

`ifdef SOBEL_MAG_EN
    localparam int MW = DATA_W + 4;
    localparam logic [MW-1:0] UMAX = MW'((2 ** GRAD_W) - 1);
    logic [SW-1:0]     ax, ay;
    logic [MW-1:0]     msum;
    logic [GRAD_W-1:0] mag_q;

    always_comb begin
        ax   = gx3[SW-1] ? SW'(-gx3) : SW'(gx3);
        ay   = gy3[SW-1] ? SW'(-gy3) : SW'(gy3);
        msum = (MW'(ax) + MW'(ay)) >> SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mag_q <= '0;
        else if (v3)
            mag_q <= b3 ? '0 : (msum > UMAX) ? UMAX[GRAD_W-1:0] : msum[GRAD_W-1:0];
    end

    assign mag = mag_q;
`else
    assign mag = '0;
`endif
endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb_sobel_stream_filter: directed Sobel streams on an 8-pixel-wide image with hand-computed results.
module tb_sobel_stream_filter;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [7:0]  pix = '0;
    logic [12:0] row = '0, col = '0;
    logic        out_valid, border;
    logic [7:0]  xgrad, ygrad, mag;
    logic [12:0] rowout, colout;

`ifdef SOBEL_MAG_EN
    localparam bit MAGON = 1'b1;
`else
    localparam bit MAGON = 1'b0;
`endif

    sobel_stream_filter #(.DATA_W(8), .IMG_W(8), .COL_W(13), .ROW_W(13), .GRAD_W(8), .SHIFT(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pix(pix), .row(row), .col(col),
        .out_valid(out_valid), .xgrad(xgrad), .ygrad(ygrad), .mag(mag), .border(border),
        .rowout(rowout), .colout(colout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0, nout = 0;
    int rx [8][16], ry [8][16], rm [8][16], rb [8][16], oc [8][16], ac [8][16];
    bit got [8][16];

    // Results are filed under the input pixel's coordinates (centre + 1).
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            automatic logic [12:0] mr = rowout + 13'd1;
            automatic logic [12:0] mc = colout + 13'd1;
            nout++;
            if (mr < 13'd8 && mc < 13'd16) begin
                got[mr][mc] = 1'b1;
                rx[mr][mc]  = int'($signed(xgrad));
                ry[mr][mc]  = int'($signed(ygrad));
                rm[mr][mc]  = int'(mag);
                rb[mr][mc]  = int'(border);
                oc[mr][mc]  = cyc;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pv(input int k, input int r, input int c);
        case (k)
            0: return (c >= 4) ? 255 : 0;
            1: return (c < 4) ? 255 : 0;
            2: return (r >= 3) ? 200 : 0;
            3: return (r + c >= 6) ? 255 : 0;
            default: return 255;
        endcase
    endfunction

    task automatic pixel(input int r, input int c, input int val);
        @(negedge clk);
        in_valid = 1'b1;
        pix = val[7:0];
        row = r[12:0];
        col = c[12:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (r < 8 && c < 16) ac[r][c] = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            pix = 8'hA5;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                got[r][c] = 1'b0;
        nout = 0;
    endtask

    task automatic frame(input string tag, input int k, input int nrows, input bit gap, input bit extra);
        int n, bad, i;
        clear();
        n = 0;
        i = 0;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < (extra ? 10 : 8); c++) begin
                if (c == 8) continue;
                pixel(r, c, pv(k, r, c));
                n++;
                if (gap) idle((i % 2 == 0) ? 2 : 1);
                i++;
            end
        end
        idle(6);
        bad = 0;
        for (int r = 0; r < nrows; r++)
            for (int c = 0; c < (extra ? 10 : 8); c++)
                if (c != 8 && (!got[r][c] || oc[r][c] - ac[r][c] != 3)) bad++;
        chk({tag, "_latency"}, bad, 0);
        chk({tag, "_count"}, nout, n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_x", int'(xgrad), 0);
        chk("rst_rowout", int'(rowout), 0);
        rst_n = 1'b1;
        clear();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++) pixel(r, c, pv(0, r, c));
        for (int c = 0; c < 6; c++) pixel(2, c, pv(0, 2, c));
        idle(3);
        chk("pre_rst_x", int'($signed(xgrad)), 127);
        chk("pre_rst_colout", int'(colout), 4);
        pixel(2, 6, 255);
        pixel(2, 7, 255);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_x", int'(xgrad), 0);
        chk("async_rst_rowout", int'(rowout), 0);
        chk("async_rst_colout", int'(colout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear();
        idle(8);
        chk("no_valid_after_rst", nout, 0);

        frame("vert", 0, 5, 1'b0, 1'b0);
        chk("vert_x24", rx[2][4], 127);
        chk("vert_y24", ry[2][4], 0);
        chk("vert_b24", rb[2][4], 0);
        chk("vert_m24", rm[2][4], MAGON ? 127 : 0);
        chk("vert_x25", rx[2][5], 127);
        chk("vert_x26", rx[2][6], 0);
        chk("vert_b03", rb[0][3], 1);
        chk("vert_x03", rx[0][3], 0);
        chk("vert_b15", rb[1][5], 1);
        chk("vert_x15", rx[1][5], 0);
        chk("vert_b00_wrap", rb[0][0], 1);
        chk("vert_b21", rb[2][1], 1);

        frame("inv", 1, 5, 1'b0, 1'b0);
        chk("inv_x24", rx[2][4], -128);
        chk("inv_y24", ry[2][4], 0);

        frame("horiz", 2, 5, 1'b0, 1'b0);
        chk("horiz_y34", ry[3][4], 100);
        chk("horiz_x34", rx[3][4], 0);

        frame("gap", 0, 5, 1'b1, 1'b1);
        chk("gap_x24", rx[2][4], 127);
        chk("gap_y24", ry[2][4], 0);
        chk("gap_x25", rx[2][5], 127);
        chk("gap_x26", rx[2][6], 0);
        chk("gap_b29", rb[2][9], 1);
        chk("gap_x29", rx[2][9], 0);
        chk("gap_m29", rm[2][9], 0);
        chk("gap_x34", rx[3][4], 127);
        chk("gap_y34", ry[3][4], 0);

        frame("diag", 3, 5, 1'b0, 1'b0);
        chk("diag_x34", rx[3][4], 95);
        chk("diag_y34", ry[3][4], 95);
        chk("diag_m34", rm[3][4], MAGON ? 191 : 0);

        frame("flat", 4, 5, 1'b0, 1'b0);
        chk("flat_x34", rx[3][4], 0);
        chk("flat_m34", rm[3][4], 0);
        chk("flat_b34", rb[3][4], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
